// File: rtl/branch_resolve_pkg.sv
// Shared types for the execute-stage branch resolution slice.
// The optional performance counters in branch_resolve_unit are enabled by
// defining BRANCH_RESOLVE_PERF_EN.
package branch_resolve_pkg;

   // Architectural register / PC width used by the packed record types below.
   localparam int ARCH_XLEN = 32;

   typedef logic [ARCH_XLEN-1:0] arch_reg_t;

   // Control-flow class of the instruction in execute.
   typedef enum logic [1:0] {
      KIND_NONE   = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JAL    = 2'd2,
      KIND_JALR   = 2'd3
   } branch_kind_t;

   // Resolution FSM: IDLE accepts work, REDIRECT holds a request to fetch.
   typedef enum logic [0:0] {
      RESOLVE_IDLE     = 1'b0,
      RESOLVE_REDIRECT = 1'b1
   } resolve_state_t;

   // Redirect request handed to fetch.
   typedef struct packed {
      arch_reg_t pc;
   } redirect_t;

   // Predictor training record.
   typedef struct packed {
      arch_reg_t pc;
      logic      taken;
      arch_reg_t target;
   } update_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target / direction / next-PC computation for one
// control-flow instruction. No compressed ISA, so only target[1] marks a
// misaligned destination.
module branch_target_calc #(
   parameter int XLEN = 32
) (
   input  logic [1:0]      kind_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic            branch_result_i,
   output logic [XLEN-1:0] target_o,
   output logic            taken_o,
   output logic [XLEN-1:0] next_pc_o,
   output logic            misaligned_o
);
   import branch_resolve_pkg::*;

   branch_kind_t kind_s;
   logic [XLEN-1:0] pc_plus4_s;
   logic [XLEN-1:0] jalr_mask_s;

   assign kind_s      = branch_kind_t'(kind_i);
   assign pc_plus4_s  = pc_i + {{(XLEN-3){1'b0}}, 3'b100};
   assign jalr_mask_s = {{(XLEN-1){1'b1}}, 1'b0};

   // Select target and direction by instruction kind (all sums wrap modulo 2^XLEN).
   always_comb begin
      target_o = pc_i + imm_i;
      taken_o  = 1'b0;
      case (kind_s)
         KIND_BRANCH: begin
            target_o = pc_i + imm_i;
            taken_o  = branch_result_i;
         end
         KIND_JAL: begin
            target_o = pc_i + imm_i;
            taken_o  = 1'b1;
         end
         KIND_JALR: begin
            target_o = (rs1_i + imm_i) & jalr_mask_s;
            taken_o  = 1'b1;
         end
         KIND_NONE: begin
            target_o = pc_i + imm_i;
            taken_o  = 1'b0;
         end
         default: begin
            target_o = pc_i + imm_i;
            taken_o  = 1'b0;
         end
      endcase
   end

   assign next_pc_o    = taken_o ? target_o : pc_plus4_s;
   assign misaligned_o = taken_o & target_o[1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compares the computed next PC with the
// fetch prediction, raises a held redirect plus a one-cycle flush on a
// mispredict, and emits predictor-update and misaligned-target pulses.
// Define BRANCH_RESOLVE_PERF_EN to build the saturating performance counters;
// otherwise the perf ports are tied to zero.
module branch_resolve_unit #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [XLEN-1:0]      in_rs1,
   input  logic [1:0]           in_kind,
   input  logic                 in_branch_result,
   input  logic                 in_pred_taken,
   input  logic [XLEN-1:0]      in_pred_target,
   output logic                 redirect_valid,
   input  logic                 redirect_ready,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 flush,
   output logic                 upd_valid,
   output logic [XLEN-1:0]      upd_pc,
   output logic                 upd_taken,
   output logic [XLEN-1:0]      upd_target,
   output logic                 misalign_valid,
   output logic [XLEN-1:0]      misalign_pc,
   output logic [XLEN-1:0]      misalign_addr,
   output logic [CNT_WIDTH-1:0] perf_resolved,
   output logic [CNT_WIDTH-1:0] perf_mispredict
);
   import branch_resolve_pkg::*;

   resolve_state_t  state_q;
   logic            ready_q;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            flush_q;
   logic            upd_valid_q;
   logic [XLEN-1:0] upd_pc_q;
   logic            upd_taken_q;
   logic [XLEN-1:0] upd_target_q;
   logic            misalign_valid_q;
   logic [XLEN-1:0] misalign_pc_q;
   logic [XLEN-1:0] misalign_addr_q;

   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] next_pc_s;
   logic            taken_s;
   logic            misaligned_s;
   logic            accept_s;
   logic            mispredict_s;
   logic            resolved_s;
   logic            enter_redirect_s;
   logic            misalign_evt_s;

   branch_target_calc #(
      .XLEN (XLEN)
   ) u_target_calc (
      .kind_i          (in_kind),
      .pc_i            (in_pc),
      .imm_i           (in_imm),
      .rs1_i           (in_rs1),
      .branch_result_i (in_branch_result),
      .target_o        (target_s),
      .taken_o         (taken_s),
      .next_pc_o       (next_pc_s),
      .misaligned_o    (misaligned_s)
   );

   // ready_q is only set in IDLE, so accepts cannot happen during REDIRECT.
   assign accept_s         = in_valid & ready_q;
   assign mispredict_s     = (in_pred_taken != taken_s) |
                             (taken_s & (in_pred_target != target_s));
   assign resolved_s       = accept_s & (in_kind != KIND_NONE) & ~misaligned_s;
   assign enter_redirect_s = accept_s & ~misaligned_s & mispredict_s;
   assign misalign_evt_s   = accept_s & misaligned_s;

   // Resolution FSM with all outputs registered one cycle after accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= RESOLVE_IDLE;
         ready_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= {XLEN{1'b0}};
         flush_q          <= 1'b0;
         upd_valid_q      <= 1'b0;
         upd_pc_q         <= {XLEN{1'b0}};
         upd_taken_q      <= 1'b0;
         upd_target_q     <= {XLEN{1'b0}};
         misalign_valid_q <= 1'b0;
         misalign_pc_q    <= {XLEN{1'b0}};
         misalign_addr_q  <= {XLEN{1'b0}};
      end else begin
         upd_valid_q      <= resolved_s;
         misalign_valid_q <= misalign_evt_s;
         if (resolved_s) begin
            upd_pc_q     <= in_pc;
            upd_taken_q  <= taken_s;
            upd_target_q <= target_s;
         end
         if (misalign_evt_s) begin
            misalign_pc_q   <= in_pc;
            misalign_addr_q <= target_s;
         end
         case (state_q)
            RESOLVE_IDLE: begin
               flush_q <= 1'b0;
               ready_q <= 1'b1;
               if (enter_redirect_s) begin
                  state_q          <= RESOLVE_REDIRECT;
                  ready_q          <= 1'b0;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= next_pc_s;
                  flush_q          <= 1'b1;
               end
            end
            RESOLVE_REDIRECT: begin
               flush_q <= 1'b0;
               if (redirect_valid_q && redirect_ready) begin
                  state_q          <= RESOLVE_IDLE;
                  ready_q          <= 1'b1;
                  redirect_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q          <= RESOLVE_IDLE;
               ready_q          <= 1'b1;
               redirect_valid_q <= 1'b0;
               flush_q          <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready       = ready_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush          = flush_q;
   assign upd_valid      = upd_valid_q;
   assign upd_pc         = upd_pc_q;
   assign upd_taken      = upd_taken_q;
   assign upd_target     = upd_target_q;
   assign misalign_valid = misalign_valid_q;
   assign misalign_pc    = misalign_pc_q;
   assign misalign_addr  = misalign_addr_q;

`ifdef BRANCH_RESOLVE_PERF_EN
   logic [CNT_WIDTH-1:0] perf_resolved_q;
   logic [CNT_WIDTH-1:0] perf_mispredict_q;

   // Saturating event counters, counted alongside the pulses they track.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_resolved_q   <= {CNT_WIDTH{1'b0}};
         perf_mispredict_q <= {CNT_WIDTH{1'b0}};
      end else begin
         if (resolved_s && (perf_resolved_q != {CNT_WIDTH{1'b1}})) begin
            perf_resolved_q <= perf_resolved_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (enter_redirect_s && (perf_mispredict_q != {CNT_WIDTH{1'b1}})) begin
            perf_mispredict_q <= perf_mispredict_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   assign perf_resolved   = perf_resolved_q;
   assign perf_mispredict = perf_mispredict_q;
`else
   assign perf_resolved   = {CNT_WIDTH{1'b0}};
   assign perf_mispredict = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results are queued when
// an instruction is driven and compared one cycle later.
module tb_branch_resolve_unit;
   localparam int XLEN = 32;
   localparam int CNTW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_pc = '0;
   logic [31:0]     in_imm = '0;
   logic [31:0]     in_rs1 = '0;
   logic [1:0]      in_kind = 2'd0;
   logic            in_branch_result = 1'b0;
   logic            in_pred_taken = 1'b0;
   logic [31:0]     in_pred_target = '0;
   logic            redirect_valid;
   logic            redirect_ready = 1'b0;
   logic [31:0]     redirect_pc;
   logic            flush;
   logic            upd_valid;
   logic [31:0]     upd_pc;
   logic            upd_taken;
   logic [31:0]     upd_target;
   logic            misalign_valid;
   logic [31:0]     misalign_pc;
   logic [31:0]     misalign_addr;
   logic [CNTW-1:0] perf_resolved;
   logic [CNTW-1:0] perf_mispredict;

   typedef struct {
      bit          upd;
      logic [31:0] upd_pc;
      bit          upd_taken;
      logic [31:0] upd_tgt;
      bit          mis;
      logic [31:0] mis_pc;
      logic [31:0] mis_addr;
      bit          redir;
      logic [31:0] redir_pc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   redir_b;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_WIDTH(CNTW)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_pc            (in_pc),
      .in_imm           (in_imm),
      .in_rs1           (in_rs1),
      .in_kind          (in_kind),
      .in_branch_result (in_branch_result),
      .in_pred_taken    (in_pred_taken),
      .in_pred_target   (in_pred_target),
      .redirect_valid   (redirect_valid),
      .redirect_ready   (redirect_ready),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .misalign_valid   (misalign_valid),
      .misalign_pc      (misalign_pc),
      .misalign_addr    (misalign_addr),
      .perf_resolved    (perf_resolved),
      .perf_mispredict  (perf_mispredict)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model of one instruction, straight from the behavioural rules.
   function automatic exp_t model(input logic [1:0] k, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [31:0] rs1,
                                  input bit res, input bit pt, input logic [31:0] ptgt);
      exp_t        e;
      logic [31:0] tgt;
      logic [31:0] npc;
      bit          taken;
      bit          mis;
      bit          mp;
      tgt   = (k == 2'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      taken = (k == 2'd1) ? res : (k >= 2'd2);
      npc   = taken ? tgt : (pc + 32'd4);
      mis   = taken && tgt[1];
      mp    = (pt != taken) || (taken && (ptgt != tgt));
      e.upd       = (k != 2'd0) && !mis;
      e.upd_pc    = pc;
      e.upd_taken = taken;
      e.upd_tgt   = tgt;
      e.mis       = mis;
      e.mis_pc    = pc;
      e.mis_addr  = tgt;
      e.redir     = !mis && mp;
      e.redir_pc  = npc;
      return e;
   endfunction

   task automatic send(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input bit res, input bit pt,
                       input logic [31:0] ptgt, output bit redir);
      exp_t e;
      check_val("ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_kind = k; in_pc = pc; in_imm = imm; in_rs1 = rs1;
      in_branch_result = res; in_pred_taken = pt; in_pred_target = ptgt;
      exp_q.push_back(model(k, pc, imm, rs1, res, pt, ptgt));
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = exp_q.pop_front();
      check_val("upd_valid", upd_valid, e.upd);
      if (e.upd) begin
         check_val("upd_pc", upd_pc, e.upd_pc);
         check_val("upd_taken", upd_taken, e.upd_taken);
         check_val("upd_target", upd_target, e.upd_tgt);
      end
      check_val("misalign_valid", misalign_valid, e.mis);
      if (e.mis) begin
         check_val("misalign_pc", misalign_pc, e.mis_pc);
         check_val("misalign_addr", misalign_addr, e.mis_addr);
      end
      check_val("flush", flush, e.redir);
      check_val("redirect_valid", redirect_valid, e.redir);
      if (e.redir) check_val("redirect_pc", redirect_pc, e.redir_pc);
      redir = e.redir;
   endtask

   // Hold redirect_ready low for 'stall' cycles, then complete the handshake.
   task automatic finish_redirect(input int stall, input logic [31:0] rpc);
      redirect_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         check_val("hold_redirect_valid", redirect_valid, 1);
         check_val("hold_redirect_pc", redirect_pc, rpc);
         check_val("hold_in_ready", in_ready, 0);
         check_val("hold_flush", flush, (i == 0));
         in_valid = 1'b1; in_kind = 2'd2; in_pc = 32'h500; in_imm = 32'h8; in_pred_taken = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check_val("blocked_upd_valid", upd_valid, 0);
         check_val("blocked_misalign", misalign_valid, 0);
      end
      check_val("last_redirect_valid", redirect_valid, 1);
      check_val("last_redirect_pc", redirect_pc, rpc);
      check_val("last_flush", flush, (stall == 0));
      check_val("last_in_ready", in_ready, 0);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      check_val("done_redirect_valid", redirect_valid, 0);
      check_val("done_in_ready", in_ready, 1);
      check_val("done_flush", flush, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_in_ready"}, in_ready, 0);
      check_val({tag, "_redirect_valid"}, redirect_valid, 0);
      check_val({tag, "_redirect_pc"}, redirect_pc, 0);
      check_val({tag, "_flush"}, flush, 0);
      check_val({tag, "_upd_valid"}, upd_valid, 0);
      check_val({tag, "_upd_pc"}, upd_pc, 0);
      check_val({tag, "_upd_target"}, upd_target, 0);
      check_val({tag, "_misalign_valid"}, misalign_valid, 0);
      check_val({tag, "_misalign_addr"}, misalign_addr, 0);
      check_val({tag, "_perf_resolved"}, perf_resolved, 0);
      check_val({tag, "_perf_mispredict"}, perf_mispredict, 0);
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("ready_after_reset", in_ready, 1);

      // Correct predictions, back to back.
      send(2'd1, 32'h100, 32'h20, 32'h0, 1'b1, 1'b1, 32'h120, redir_b);
      send(2'd2, 32'h10, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 32'h0, redir_b);
      send(2'd1, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, redir_b);
      send(2'd0, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, redir_b);

      // Direction mispredict with a stalled fetch.
      send(2'd1, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 32'h120, redir_b);
      check_val("mp1_redir", redir_b, 1);
      finish_redirect(3, 32'h104);

      // JALR predicted not-taken; fetch ready on the first REDIRECT cycle.
      send(2'd3, 32'h40, 32'h3, 32'h2001, 1'b0, 1'b0, 32'h0, redir_b);
      finish_redirect(0, 32'h2004);

      // Misaligned JALR target.
      send(2'd3, 32'h44, 32'h2, 32'h2000, 1'b0, 1'b1, 32'h2002, redir_b);

      // Fall-through wraps to zero.
      send(2'd1, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b1, 32'h4, redir_b);
      finish_redirect(1, 32'h0);

      // Non-control-flow instruction predicted taken.
      send(2'd0, 32'h600, 32'h0, 32'h0, 1'b0, 1'b1, 32'h700, redir_b);
      finish_redirect(0, 32'h604);

      // Target mispredict: right direction, wrong target.
      send(2'd2, 32'h800, 32'h100, 32'h0, 1'b0, 1'b1, 32'h904, redir_b);
      finish_redirect(0, 32'h900);

      // Reset in the middle of a REDIRECT drops the pending redirect.
      send(2'd1, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 32'h120, redir_b);
      redirect_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; redirect_ready = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midreset");
      rst = 1'b0; redirect_ready = 1'b0;
      @(posedge clk); #1;
      check_val("midreset_ready_after", in_ready, 1);
      check_val("midreset_no_redirect", redirect_valid, 0);

      // Five mispredicts against 2-bit saturating counters.
      for (int n = 0; n < 5; n++) begin
         send(2'd1, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 32'h120, redir_b);
         finish_redirect(0, 32'h104);
      end
`ifdef BRANCH_RESOLVE_PERF_EN
      check_val("perf_mispredict", perf_mispredict, 3);
      check_val("perf_resolved", perf_resolved, 3);
`else
      check_val("perf_mispredict_off", perf_mispredict, 0);
      check_val("perf_resolved_off", perf_resolved, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
